// File: rtl/fir_pkg.sv
// Shared FIR post-processing definitions: default widths and the
// round/shift/saturate helper reused by the output-side stages.
package fir_pkg;

    localparam int unsigned FIR_PRODUCT_WIDTH = 32;
    localparam int unsigned FIR_DATAWIDTH     = 16;
    localparam int unsigned FIR_FRAC_SHIFT    = 15;
    localparam int unsigned FIR_BUF_DEPTH     = 4;

    // Working width for the helper; callers sign-extend into it and keep low bits.
    localparam int unsigned RSS_W = 64;

    typedef struct packed {
        logic [RSS_W-1:0] value;
        logic             sat;
    } rss_t;

    function automatic rss_t round_shift_sat(
        input logic signed [RSS_W-1:0] x,
        input int unsigned             frac_shift,
        input int unsigned             out_width,
        input logic                    rnd,
        input logic                    sat
    );
        logic signed [RSS_W:0] acc;
        logic signed [RSS_W:0] hi;
        logic signed [RSS_W:0] lo;
        rss_t                  r;
        acc = {x[RSS_W-1], x};
        if (rnd && (frac_shift > 0))
            acc = acc + ((RSS_W+1)'(1) << (frac_shift - 1));
        acc = acc >>> frac_shift;
        hi  = ((RSS_W+1)'(1) << (out_width - 1)) - (RSS_W+1)'(1);
        lo  = -hi - (RSS_W+1)'(1);
        r.value = acc[RSS_W-1:0];
        r.sat   = 1'b0;
        if (sat) begin
            if (acc > hi) begin
                r.value = hi[RSS_W-1:0];
                r.sat   = 1'b1;
            end else if (acc < lo) begin
                r.value = lo[RSS_W-1:0];
                r.sat   = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Generic show-ahead FIFO: head entry always on dout, zero when empty.
module fir_out_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_req,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_req,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       push_ok
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;

    // A write is accepted when full only if the head leaves in the same cycle.
    always_comb begin
        pop     = valid & rd_req;
        push_ok = wr_req & (~full | pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            mem[wr_ptr] <= din;
    end

    always_comb begin
        valid = (count != '0);
        full  = (count == CW'(DEPTH));
        dout  = valid ? mem[rd_ptr] : '0;
    end

endmodule

// File: rtl/fir_out_buf.sv
// FIR output stage: round/shift/narrow the accumulator result and buffer it
// in a show-ahead FIFO with valid/ready toward the sample sink.
module fir_out_buf
    import fir_pkg::*;
#(
    parameter int unsigned PRODUCT_WIDTH = FIR_PRODUCT_WIDTH,
    parameter int unsigned OUT_WIDTH     = FIR_DATAWIDTH,
    parameter int unsigned FRAC_SHIFT    = FIR_FRAC_SHIFT,
    parameter int unsigned DEPTH         = FIR_BUF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PRODUCT_WIDTH-1:0]     tin_y,
    input  logic                         ld_y,
    input  logic                         rnd_en,
    input  logic                         sat_en,
    output logic [OUT_WIDTH-1:0]         tout_y,
    output logic                         tout_valid,
    input  logic                         tout_ready,
    output logic                         full,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         ovf_sticky,
    output logic                         sat_sticky,
    input  logic                         clr_flags
);

    logic signed [RSS_W-1:0] x_ext;
    rss_t                    conv;
    logic [OUT_WIDTH-1:0]    conv_y;
    logic                    push_ok;
    logic                    drop;
    logic                    sat_evt;

    always_comb begin
        x_ext   = {{(RSS_W-PRODUCT_WIDTH){tin_y[PRODUCT_WIDTH-1]}}, tin_y};
        conv    = round_shift_sat(x_ext, FRAC_SHIFT, OUT_WIDTH, rnd_en, sat_en);
        conv_y  = conv.value[OUT_WIDTH-1:0];
        drop    = ld_y & ~push_ok;
        sat_evt = push_ok & conv.sat;
    end

    fir_out_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_req  (ld_y),
        .din     (conv_y),
        .rd_req  (tout_ready),
        .dout    (tout_y),
        .valid   (tout_valid),
        .full    (full),
        .count   (count),
        .push_ok (push_ok)
    );

    // Setting beats clearing when both happen in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            sat_sticky <= 1'b0;
        end else begin
            ovf_sticky <= (ovf_sticky & ~clr_flags) | drop;
            sat_sticky <= (sat_sticky & ~clr_flags) | sat_evt;
        end
    end

endmodule

// File: tb/tb_fir_out_buf.sv
// Directed bench for fir_out_buf: conversion table plus FIFO corner sequences.
module tb_fir_out_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tin_y;
    logic        ld_y;
    logic        rnd_en;
    logic        sat_en;
    logic [15:0] tout_y;
    logic        tout_valid;
    logic        tout_ready;
    logic        full;
    logic [2:0]  count;
    logic        ovf_sticky;
    logic        sat_sticky;
    logic        clr_flags;

    int n_checks = 0;
    int n_fail   = 0;

    fir_out_buf #(
        .PRODUCT_WIDTH (32),
        .OUT_WIDTH     (16),
        .FRAC_SHIFT    (15),
        .DEPTH         (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tin_y      (tin_y),
        .ld_y       (ld_y),
        .rnd_en     (rnd_en),
        .sat_en     (sat_en),
        .tout_y     (tout_y),
        .tout_valid (tout_valid),
        .tout_ready (tout_ready),
        .full       (full),
        .count      (count),
        .ovf_sticky (ovf_sticky),
        .sat_sticky (sat_sticky),
        .clr_flags  (clr_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] tin;
        logic        rnd;
        logic        sat;
        logic [15:0] exp_y;
        logic        exp_flag;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] v, input logic r, input logic s);
        tin_y  = v;
        rnd_en = r;
        sat_en = s;
        ld_y   = 1'b1;
        tick();
        ld_y   = 1'b0;
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
    endtask

    task automatic drain(input int n);
        tout_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
        tout_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'h0000_4000, 1'b1, 1'b1, 16'h0001, 1'b0};
        vecs[1]  = '{32'h0000_4000, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[2]  = '{32'h4000_0000, 1'b0, 1'b1, 16'h7FFF, 1'b1};
        vecs[3]  = '{32'h4000_0000, 1'b0, 1'b0, 16'h8000, 1'b0};
        vecs[4]  = '{32'hC000_0000, 1'b0, 1'b1, 16'h8000, 1'b0};
        vecs[5]  = '{32'hBFFF_8000, 1'b0, 1'b1, 16'h8000, 1'b1};
        vecs[6]  = '{32'h0001_4000, 1'b1, 1'b1, 16'h0003, 1'b0};
        vecs[7]  = '{32'h0001_3FFF, 1'b1, 1'b1, 16'h0002, 1'b0};
        vecs[8]  = '{32'hFFFF_C000, 1'b1, 1'b1, 16'h0000, 1'b0};
        vecs[9]  = '{32'hFFFF_C000, 1'b0, 1'b1, 16'hFFFF, 1'b0};
        vecs[10] = '{32'h7FFF_FFFF, 1'b1, 1'b1, 16'h7FFF, 1'b1};
        vecs[11] = '{32'h7FFF_FFFF, 1'b1, 1'b0, 16'h0000, 1'b0};

        rst = 1'b1; tin_y = '0; ld_y = 1'b0; rnd_en = 1'b0; sat_en = 1'b0;
        tout_ready = 1'b0; clr_flags = 1'b0;
        tick();
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(tout_valid), 32'd0);
        check("rst_y", 32'(tout_y), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_flags", {30'd0, ovf_sticky, sat_sticky}, 32'd0);
        rst = 1'b0;

        // Single-sample conversion table: push, inspect head, pop.
        for (int i = 0; i < 12; i++) begin
            clear_flags();
            push(vecs[i].tin, vecs[i].rnd, vecs[i].sat);
            check($sformatf("vec%0d_y", i), 32'(tout_y), 32'(vecs[i].exp_y));
            check($sformatf("vec%0d_valid", i), 32'(tout_valid), 32'd1);
            check($sformatf("vec%0d_satflag", i), 32'(sat_sticky), 32'(vecs[i].exp_flag));
            drain(1);
            check($sformatf("vec%0d_empty", i), {31'd0, tout_valid}, 32'd0);
        end

        // Fill and overflow.
        clear_flags();
        for (int k = 1; k <= 5; k++) begin
            push(32'(k) << 15, 1'b0, 1'b1);
            check($sformatf("fill%0d_count", k), 32'(count), (k < 4) ? 32'(k) : 32'd4);
            check($sformatf("fill%0d_full", k), 32'(full), (k >= 4) ? 32'd1 : 32'd0);
            check($sformatf("fill%0d_ovf", k), 32'(ovf_sticky), (k == 5) ? 32'd1 : 32'd0);
        end
        tout_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("pop%0d_y", k), 32'(tout_y), 32'(k));
            tick();
        end
        tout_ready = 1'b0;
        check("drained_valid", 32'(tout_valid), 32'd0);
        check("drained_y", 32'(tout_y), 32'd0);
        check("drained_count", 32'(count), 32'd0);

        // Full with simultaneous push and pop.
        clear_flags();
        for (int k = 10; k <= 13; k++) push(32'(k) << 15, 1'b0, 1'b1);
        check("pp_full", 32'(full), 32'd1);
        tout_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pp%0d_head", i), 32'(tout_y), 32'(10 + i));
            push(32'(20 + i) << 15, 1'b0, 1'b1);
            check($sformatf("pp%0d_count", i), 32'(count), 32'd4);
        end
        check("pp_ovf", 32'(ovf_sticky), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pp_drain%0d", i), 32'(tout_y), (i == 0) ? 32'd13 : 32'(19 + i));
            tick();
        end
        tout_ready = 1'b0;
        check("pp_empty", 32'(tout_valid), 32'd0);

        // Reset mid-stream with flags set.
        clear_flags();
        push(32'h4000_0000, 1'b0, 1'b1);
        for (int k = 2; k <= 5; k++) push(32'(k) << 15, 1'b0, 1'b1);
        drain(1);
        check("prerst_count", 32'(count), 32'd3);
        check("prerst_flags", {30'd0, ovf_sticky, sat_sticky}, 32'd3);
        rst = 1'b1;
        ld_y = 1'b1;
        tick();
        rst = 1'b0;
        ld_y = 1'b0;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_valid", 32'(tout_valid), 32'd0);
        check("midrst_flags", {30'd0, ovf_sticky, sat_sticky}, 32'd0);

        // Clear in the same cycle as an overflowing saturating push.
        for (int k = 1; k <= 4; k++) push(32'(k) << 15, 1'b0, 1'b1);
        clr_flags = 1'b1;
        push(32'h4000_0000, 1'b0, 1'b1);
        clr_flags = 1'b0;
        check("setwins_ovf", 32'(ovf_sticky), 32'd1);
        check("drop_nosat", 32'(sat_sticky), 32'd0);
        check("drop_head", 32'(tout_y), 32'd1);
        clear_flags();
        check("clr_ovf", 32'(ovf_sticky), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
